// File: rtl/baud_tick_gen_frac_pkg.sv
// Shared constants and types for the fractional baud tick generator.
package baud_pkg;

  typedef enum logic {
    OSR16 = 1'b0,
    OSR8  = 1'b1
  } osr_e;

  localparam int MIN_DIV      = 2;
  localparam int DEF_DIV_INT  = 325;
  localparam int DEF_DIV_FRAC = 8;

endpackage

// File: rtl/baud_tick_gen_frac_divider.sv
// Fractional clock divider: one-cycle registered tick every int or int+1 enabled clocks.
// First tick lands i_int enabled clocks after restart/reset; i_en low freezes all state.
module frac_divider #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_en,
  input  logic              i_restart,
  input  logic [INT_W-1:0]  i_int,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_tick
);

  logic [INT_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic              r_tick;

  logic [INT_W:0]    w_last;
  logic              w_end;
  logic [FRAC_W:0]   w_acc_sum;

  // A carry out of the accumulator stretches the following period by one clock.
  assign w_last    = {1'b0, i_int} + {{INT_W{1'b0}}, r_carry} - {{INT_W{1'b0}}, 1'b1};
  assign w_end     = ({1'b0, r_cnt} == w_last);
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, i_frac};

  always_ff @(posedge clk) begin
    if (!resetn || i_restart) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_tick  <= 1'b0;
    end else if (i_en) begin
      if (w_end) begin
        r_cnt   <= '0;
        r_acc   <= w_acc_sum[FRAC_W-1:0];
        r_carry <= w_acc_sum[FRAC_W];
        r_tick  <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + INT_W'(1);
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/baud_tick_gen_frac.sv
// UART rx oversample / tx bit tick generator with fractional divisor and shadowed config.
// Ticks are registered; new config waits in a shadow until the cycle after a tx_tick (or at once when idle).
module baud_tick_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int DEF_INT  = DEF_DIV_INT,
  parameter int DEF_FRAC = DEF_DIV_FRAC
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              osr8,
  input  logic              cfg_load,
  output logic              cfg_busy,
  input  logic              rx_resync,
  output logic              rx_tick,
  output logic              tx_tick
);

  localparam int TX_W = DIV_W + 4;
  localparam int V_W  = DIV_W + FRAC_W;
  localparam int VX_W = V_W + 4;

  logic [DIV_W-1:0]  r_sh_int;
  logic [FRAC_W-1:0] r_sh_frac;
  osr_e              r_sh_osr;
  logic              r_busy;
  logic [DIV_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  osr_e              r_act_osr;

  logic [DIV_W-1:0]  w_int_c;
  logic [V_W-1:0]    w_v;
  logic [VX_W-1:0]   w_vx;
  logic [TX_W-1:0]   w_tx_int;
  logic [FRAC_W-1:0] w_tx_frac;
  logic              w_apply;
  logic              w_rx_tick;
  logic              w_tx_tick;

  assign w_int_c   = (r_act_int < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : r_act_int;
  assign w_v       = {w_int_c, r_act_frac};
  // tx period is V scaled by the oversampling ratio, split back into int/frac.
  assign w_vx      = (r_act_osr == OSR8) ? {1'b0, w_v, 3'b000} : {w_v, 4'b0000};
  assign w_tx_int  = w_vx[VX_W-1:FRAC_W];
  assign w_tx_frac = w_vx[FRAC_W-1:0];

  assign w_apply   = r_busy & (w_tx_tick | ~en);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy     <= 1'b0;
      r_sh_int   <= '0;
      r_sh_frac  <= '0;
      r_sh_osr   <= OSR16;
      r_act_int  <= DIV_W'(DEF_INT);
      r_act_frac <= FRAC_W'(DEF_FRAC);
      r_act_osr  <= OSR16;
    end else begin
      if (w_apply) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
        r_act_osr  <= r_sh_osr;
      end
      // A load in the apply cycle becomes a fresh pending load.
      if (cfg_load) begin
        r_sh_int  <= div_int;
        r_sh_frac <= div_frac;
        r_sh_osr  <= osr8 ? OSR8 : OSR16;
        r_busy    <= 1'b1;
      end else if (w_apply) begin
        r_busy    <= 1'b0;
      end
    end
  end

  frac_divider #(
    .INT_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_rx_div (
    .clk       (clk),
    .resetn    (resetn),
    .i_en      (en),
    .i_restart (w_apply | rx_resync),
    .i_int     (w_int_c),
    .i_frac    (r_act_frac),
    .o_tick    (w_rx_tick)
  );

  frac_divider #(
    .INT_W  (TX_W),
    .FRAC_W (FRAC_W)
  ) u_tx_div (
    .clk       (clk),
    .resetn    (resetn),
    .i_en      (en),
    .i_restart (w_apply),
    .i_int     (w_tx_int),
    .i_frac    (w_tx_frac),
    .o_tick    (w_tx_tick)
  );

  assign rx_tick  = w_rx_tick;
  assign tx_tick  = w_tx_tick;
  assign cfg_busy = r_busy;

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Scoreboard bench: a fixed-point tick-time model predicts every tick cycle; a monitor matches DUT ticks.
module tb_baud_tick_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam longint ONE = 1 << FRAC_W;

  logic              clk;
  logic              resetn;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              osr8;
  logic              cfg_load;
  logic              cfg_busy;
  logic              rx_resync;
  logic              rx_tick;
  logic              tx_tick;

  baud_tick_gen_frac dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .osr8      (osr8),
    .cfg_load  (cfg_load),
    .cfg_busy  (cfg_busy),
    .rx_resync (rx_resync),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint cyc = 0;
  longint rx_q[$];
  longint tx_q[$];

  // Reference model state: active/shadow config and enabled-clock counts since restart.
  int     m_act_int, m_act_frac, m_sh_int, m_sh_frac;
  bit     m_act_osr8, m_sh_osr8, m_busy, m_txprev;
  bit     m_apply, m_rxt, m_txt;
  longint m_rx_e, m_rx_n, m_tx_e, m_tx_n;
  longint m_v, m_vo, m_ri, m_rf, m_ti, m_tf;

  // Tick n after a restart lands once (n+1)*int + floor(n*frac/2^F) enabled clocks have elapsed.
  function automatic longint tick_time(longint n, longint i, longint f);
    return (n + 1) * i + ((n * f) / ONE);
  endfunction

  function automatic longint v_of(int i, int f);
    return longint'((i < 2) ? 2 : i) * ONE + longint'(f);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetn) begin
        m_act_int = 325; m_act_frac = 8; m_act_osr8 = 0;
        m_busy = 0; m_txprev = 0;
        m_rx_e = 0; m_rx_n = 0; m_tx_e = 0; m_tx_n = 0;
      end else begin
        m_v  = v_of(m_act_int, m_act_frac);
        m_ri = m_v / ONE;  m_rf = m_v % ONE;
        m_vo = m_v * (m_act_osr8 ? 8 : 16);
        m_ti = m_vo / ONE; m_tf = m_vo % ONE;
        m_apply = m_busy && (m_txprev || !en);
        m_rxt = 0; m_txt = 0;
        if (m_apply || rx_resync) begin
          m_rx_e = 0; m_rx_n = 0;
        end else if (en) begin
          m_rx_e++;
          if (m_rx_e == tick_time(m_rx_n, m_ri, m_rf)) begin m_rxt = 1; m_rx_n++; end
        end
        if (m_apply) begin
          m_tx_e = 0; m_tx_n = 0;
        end else if (en) begin
          m_tx_e++;
          if (m_tx_e == tick_time(m_tx_n, m_ti, m_tf)) begin m_txt = 1; m_tx_n++; end
        end
        if (m_apply) begin
          m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_act_osr8 = m_sh_osr8;
        end
        if (cfg_load) begin
          m_sh_int = int'(div_int); m_sh_frac = int'(div_frac); m_sh_osr8 = osr8;
          m_busy = 1;
        end else if (m_apply) begin
          m_busy = 0;
        end
        if (m_rxt) rx_q.push_back(cyc);
        if (m_txt) tx_q.push_back(cyc);
        m_txprev = m_txt;
      end
    end
  end

  // Monitor: pops expected tick cycles whenever the DUT presents a tick.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_tick === 1'b1) begin
        checks++;
        if (rx_q.size() == 0) begin
          failures++;
          $display("FAIL rx_tick_unexpected: tick at cycle %0d, none required", cyc);
        end else if (rx_q[0] != cyc) begin
          failures++;
          $display("FAIL rx_tick_time: tick at cycle %0d, required %0d", cyc, rx_q[0]);
          if (rx_q[0] < cyc) void'(rx_q.pop_front());
        end else void'(rx_q.pop_front());
      end else if (rx_q.size() > 0 && rx_q[0] <= cyc) begin
        checks++; failures++;
        $display("FAIL rx_tick_missing: no tick at cycle %0d, required %0d", cyc, rx_q[0]);
        void'(rx_q.pop_front());
      end
      if (tx_tick === 1'b1) begin
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_tick_unexpected: tick at cycle %0d, none required", cyc);
        end else if (tx_q[0] != cyc) begin
          failures++;
          $display("FAIL tx_tick_time: tick at cycle %0d, required %0d", cyc, tx_q[0]);
          if (tx_q[0] < cyc) void'(tx_q.pop_front());
        end else void'(tx_q.pop_front());
      end else if (tx_q.size() > 0 && tx_q[0] <= cyc) begin
        checks++; failures++;
        $display("FAIL tx_tick_missing: no tick at cycle %0d, required %0d", cyc, tx_q[0]);
        void'(tx_q.pop_front());
      end
      checks++;
      if (cfg_busy !== m_busy) begin
        failures++;
        $display("FAIL cfg_busy: got %b at cycle %0d, required %b", cfg_busy, cyc, m_busy);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input bit is_tx, input int budget, output longint t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((is_tx ? tx_tick : rx_tick) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++; failures++;
      $display("FAIL wait_%s_tick: no tick within %0d cycles, required one", is_tx ? "tx" : "rx", budget);
    end
  endtask

  task automatic quick_cfg(input int i, input int f, input bit o);
    @(negedge clk);
    en = 0; div_int = DIV_W'(i); div_frac = FRAC_W'(f); osr8 = o; cfg_load = 1;
    @(negedge clk);
    cfg_load = 0;
    @(negedge clk);
    en = 1;
  endtask

  task automatic reset_and_check_defaults();
    longint k, t0, t1, t2;
    @(negedge clk);
    resetn = 0; cfg_load = 0; rx_resync = 0; en = 1;
    repeat (4) @(negedge clk);
    chk("reset_outputs", longint'({rx_tick, tx_tick, cfg_busy}), 0);
    k = cyc;
    resetn = 1;
    wait_tick(0, 400, t0);
    wait_tick(0, 400, t1);
    wait_tick(0, 400, t2);
    chk("default_first_rx", t0 - k, 325);
    chk("default_rx_period_a", t1 - t0, 325);
    chk("default_rx_period_b", t2 - t1, 326);
  endtask

  longint t0, t1, ta, tb, tt, tr, c;
  int     cnt;

  initial begin
    resetn = 0; en = 1; div_int = '0; div_frac = '0; osr8 = 0;
    cfg_load = 0; rx_resync = 0;
    reset_and_check_defaults();

    // 4.0 at x16
    quick_cfg(4, 0, 0);
    wait_tick(0, 20, t0); wait_tick(0, 20, t1);
    chk("int4_rx_period", t1 - t0, 4);
    wait_tick(1, 200, t0); wait_tick(1, 200, t1);
    chk("int4_tx_period", t1 - t0, 64);

    // 4.5 at x16: 16 rx ticks per 72-clock tx bit
    quick_cfg(4, 8, 0);
    wait_tick(1, 200, ta);
    cnt = 0; tb = -1;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (rx_tick === 1'b1) cnt++;
      if (tx_tick === 1'b1) tb = cyc;
    end
    chk("frac_rx_ticks_per_72", cnt, 16);
    chk("frac_tx_period_x16", tb - ta, 72);

    quick_cfg(4, 8, 1);
    wait_tick(1, 200, t0); wait_tick(1, 200, t1);
    chk("frac_tx_period_x8", t1 - t0, 36);

    quick_cfg(1, 0, 0);
    wait_tick(0, 20, t0); wait_tick(0, 20, t1);
    chk("clamp_rx_period", t1 - t0, 2);

    // mid-bit load waits for the tx bit boundary
    quick_cfg(4, 0, 0);
    wait_tick(1, 200, tt);
    repeat (20) @(negedge clk);
    div_int = 16'd10; div_frac = '0; osr8 = 0; cfg_load = 1;
    @(negedge clk);
    cfg_load = 0;
    chk("busy_after_load", longint'(cfg_busy), 1);
    wait_tick(1, 200, tt);
    chk("busy_at_tx_tick", longint'(cfg_busy), 1);
    @(negedge clk);
    chk("busy_after_apply", longint'(cfg_busy), 0);
    wait_tick(0, 50, tr);
    chk("rx_after_apply", tr - tt, 11);

    // resync two clocks before an expected rx tick
    quick_cfg(4, 0, 0);
    wait_tick(0, 50, c);
    wait_tick(0, 50, c);
    @(negedge clk); rx_resync = 1;
    @(negedge clk); rx_resync = 0;
    wait_tick(0, 50, tr);
    chk("rx_after_resync", tr - c, 6);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          @(negedge clk);
          div_int = DIV_W'($urandom_range(0, 12)); div_frac = FRAC_W'($urandom_range(0, 15));
          osr8 = 1'($urandom_range(0, 1)); cfg_load = 1;
          @(negedge clk); cfg_load = 0;
        end
        1: begin
          @(negedge clk); en = 0;
          repeat ($urandom_range(1, 8)) @(negedge clk);
          en = 1;
        end
        2: begin
          @(negedge clk); rx_resync = 1;
          @(negedge clk); rx_resync = 0;
        end
        3: quick_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        default: ;
      endcase
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end

    // reset while a load is pending
    quick_cfg(6, 3, 0);
    repeat (10) @(negedge clk);
    div_int = 16'd9; div_frac = 4'd1; cfg_load = 1;
    @(negedge clk);
    cfg_load = 0;
    chk("busy_before_reset", longint'(cfg_busy), 1);
    reset_and_check_defaults();

    repeat (5) @(negedge clk);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
